// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction FIFO with flush on taken branch and fetch backpressure.
// Optional same-cycle bypass to decode when empty: define FDQ_BYPASS_EN.
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_instr,
  input  logic [WIDTH-1:0]         in_pcplus4,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_instr,
  output logic [WIDTH-1:0]         out_pcplus4,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pcplus4;
  } ent_t;

  ent_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          empty, byp, push, pop;
  ent_t          head;

  assign empty    = (cnt == '0);
  assign in_ready = (cnt != FULL);
  assign count    = cnt;
  assign head     = mem[rd_ptr];

`ifdef FDQ_BYPASS_EN
  assign byp = empty & in_valid & ~flush;
`else
  assign byp = 1'b0;
`endif

  // A bypassed pair consumed by decode in the same cycle is never stored.
  assign push = in_valid & in_ready & ~(byp & out_ready);
  assign pop  = ~empty & out_ready;

  always_comb begin
    out_valid   = ~empty | byp;
    out_instr   = '0;
    out_pcplus4 = '0;
    if (byp) begin
      out_instr   = in_instr;
      out_pcplus4 = in_pcplus4;
    end else if (!empty) begin
      out_instr   = head.instr;
      out_pcplus4 = head.pcplus4;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (reset && !flush && push) mem[wr_ptr] <= '{instr: in_instr, pcplus4: in_pcplus4};
  end
endmodule
